mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Multi-cycle multiply/divide unit owning the architectural HI/LO registers. It complements the single-cycle combinational ALU by executing the long-latency MIPS32 ops: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits in the EX stage beside the ALU; `busy` stalls the pipeline and `hi`/`lo` feed MFHI/MFLO forwarding.

Parameters:
W, `WORD_WIDTH (32), operand and HI/LO width
ITER, W, iterations per multiply or divide (one bit per cycle)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only while idle
md_op  in  `MDOP_WIDTH  selects MULT/MULTU/DIV/DIVU/MTHI/MTLO
op1  in  W  rs operand (dividend / multiplicand / MTxx source)
op2  in  W  rt operand (divisor / multiplier)
cancel  in  1  pipeline flush; aborts an in-flight op
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
hi  out  W  HI register
lo  out  W  LO register

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0. Reset mid-operation aborts the operation and clears HI/LO.
- States:
  - IDLE to RUN on start with a MULT, MULTU, DIV or DIVU op.
  - RUN for ITER cycles, then to FIX.
  - FIX to IDLE.
  - cancel in RUN or FIX returns to IDLE next edge; HI/LO unchanged; no done.
- Start edge:
  - Operands are latched.
  - Signed ops record sign(op1) and sign(op2) and work on absolute values. abs(0x80000000) = 0x80000000, treated as unsigned.
- RUN multiply: shift-add, one multiplier bit per cycle, into a 2W-bit accumulator.
- RUN divide: restoring, one quotient bit per cycle. Partial remainder is W+1 bits.
- FIX:
  - Apply sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Write HI/LO. done=1 for exactly this cycle.
  - HI = product[2W-1:W] or remainder. LO = product[W-1:0] or quotient.
- Latency: start sampled at edge T; hi/lo/done valid after edge T+ITER+1 (33 cycles for W=32). busy is 1 from after edge T until after edge T+ITER+1.
- MTHI/MTLO: accepted only when idle. Write hi (resp. lo) = op1 at the sampling edge. No busy, no done.
- start while busy: ignored; no state change.
- Divide by zero (DIV and DIVU): full latency; HI=op1, LO=all ones. Deterministic; no exception.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0, which is the natural wrap.
- Simultaneous start and cancel in IDLE: cancel wins; the op is not accepted.
- hi/lo outputs are registers; there is no combinational path from the inputs.

Decomposition:
- Add to defines.v: `MDOP_WIDTH; the codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI and MD_MTLO; the state encodings MD_IDLE, MD_RUN and MD_FIX.
- One natural sub-module, mdu_datapath, holding the iterative shift-add/restoring step (accumulator, partial remainder, counter). The parent keeps the FSM, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 -> hi=0x12345678, lo=0xFFFFFFFF, done after 33 cycles.
- Edge cases during an op:
  - Start MULT, then assert cancel on cycle 10 -> busy drops the next cycle, no done, hi/lo keep their prior values.
  - Repeat with rst on cycle 10 -> hi=lo=0.
- MTHI 0xAAAA5555 while idle -> hi=0xAAAA5555 after one edge, busy stays 0.
- A start pulse while busy is ignored: the first op's result is unchanged and exactly one done pulse occurs.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and the default word width.
package mul_div_unit_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int MDOP_WIDTH = 3;

  typedef enum logic [MDOP_WIDTH-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per step,
// on unsigned magnitudes. The parent owns sequencing and sign correction.
module mdu_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int W    = WORD_WIDTH,
  parameter int ITER = W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic                         is_div,
  input  logic [W-1:0]                 a,
  input  logic [W-1:0]                 b,
  output logic [$clog2(ITER+1)-1:0]    cnt,
  output logic [2*W-1:0]               prod,
  output logic [W-1:0]                 quot,
  output logic [W-1:0]                 rem
);

  localparam int CNT_W = $clog2(ITER+1);

  // acc: multiply keeps {partial product, multiplier}; divide keeps the
  // dividend/quotient shift register in its low half.
  logic [2*W-1:0] acc;
  logic [W-1:0]   opb;
  logic [W-1:0]   rem_r;
  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic           fits;

  always_comb begin
    add_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : {W{1'b0}})};
    trial   = {rem_r, acc[W-1]};
    fits    = (trial >= {1'b0, opb});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      acc   <= {{W{1'b0}}, (is_div ? a : b)};
      opb   <= is_div ? b : a;
      rem_r <= '0;
    end else if (step) begin
      if (is_div) begin
        rem_r       <= fits ? W'(trial - {1'b0, opb}) : trial[W-1:0];
        acc[W-1:0]  <= {acc[W-2:0], fits};
      end else begin
        acc <= {add_sum, acc[W-1:1]};
      end
    end
  end

  assign prod = acc;
  assign quot = acc[W-1:0];
  assign rem  = rem_r;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write directly.
// Signed ops run on magnitudes and are sign-corrected in the FIX cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int W    = WORD_WIDTH,
  parameter int ITER = W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MDOP_WIDTH-1:0] md_op,
  input  logic [W-1:0]          op1,
  input  logic [W-1:0]          op2,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          hi,
  output logic [W-1:0]          lo
);

  localparam int CNT_W = $clog2(ITER+1);

  md_state_e        state, state_nxt;
  logic             long_op, signed_op, accept, mt_req;
  logic             load, step, last, write_res;
  logic             a_neg, b_neg;
  logic [W-1:0]     a_abs, b_abs;
  logic             is_div_q, neg_q_q, neg_r_q, div_zero_q;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   prod, prod_fix;
  logic [W-1:0]     quot, rem, fix_hi, fix_lo;

  function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] x);
    return neg ? -x : x;
  endfunction

  always_comb begin
    long_op   = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                (md_op == MD_DIV)  || (md_op == MD_DIVU);
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    a_neg     = signed_op && op1[W-1];
    b_neg     = signed_op && op2[W-1];
    a_abs     = cond_neg(a_neg, op1);
    b_abs     = cond_neg(b_neg, op2);
    mt_req    = (state == MD_IDLE) && start && !cancel;
    accept    = mt_req && long_op;
    last      = (cnt == CNT_W'(ITER-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    write_res = 1'b0;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          state_nxt = MD_RUN;
          load      = 1'b1;
        end
      end
      MD_RUN: begin
        step = !cancel;
        if (cancel)    state_nxt = MD_IDLE;
        else if (last) state_nxt = MD_FIX;
      end
      MD_FIX: begin
        state_nxt = MD_IDLE;
        write_res = !cancel;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Sign bookkeeping captured with the operands; remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (load) begin
      is_div_q   <= (md_op == MD_DIV) || (md_op == MD_DIVU);
      neg_q_q    <= a_neg ^ b_neg;
      neg_r_q    <= a_neg;
      div_zero_q <= (op2 == '0);
    end
  end

  mdu_datapath #(.W(W), .ITER(ITER)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div ((md_op == MD_DIV) || (md_op == MD_DIVU) ? (load ? 1'b1 : is_div_q) : (load ? 1'b0 : is_div_q)),
    .a      (a_abs),
    .b      (b_abs),
    .cnt    (cnt),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem)
  );

  // Divide by zero yields the dividend in HI (sign restored) and all ones in LO.
  always_comb begin
    prod_fix = neg_q_q ? -prod : prod;
    if (is_div_q) begin
      fix_hi = cond_neg(neg_r_q, rem);
      fix_lo = div_zero_q ? {W{1'b1}} : cond_neg(neg_q_q, quot);
    end else begin
      fix_hi = prod_fix[2*W-1:W];
      fix_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= write_res;
      if (write_res) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (mt_req && (md_op == MD_MTHI)) begin
        hi <= op1;
      end else if (mt_req && (md_op == MD_MTLO)) begin
        lo <= op1;
      end
    end
  end

  assign busy = (state != MD_IDLE);

endmodule
